// File: rtl/rob_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// rob_recovery_ctrl
//
// Reorder-buffer recovery sequencer. A branch-mispredict redirect triggers
// this sequence:
//   1. A one-cycle front-end flush pulse.
//   2. A fixed ROLLBACK drain window of ROLLBACK_CYCLES cycles.
//   3. A youngest-first WALK over the squashed ROB entries, so rename can
//      undo its mappings.
//   4. A one-cycle tail-restore pulse to the ROB, then a return to IDLE.
//
// An older redirect that arrives during recovery retargets the sequence and
// restarts ROLLBACK. A younger redirect, or one for the same entry, is ignored.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   redirect_valid      mispredict resolved this cycle
//   redirect_rob_idx    ROB index of the mispredicted branch (the branch is kept)
//   rob_head, rob_tail  oldest entry / next free slot of the ROB
//   rob_state           00 idle, 01 rollback, 10 walk
//   flush_valid         one-cycle front-end flush pulse
//   walk_valid/walk_idx squashed entry being undone this cycle
//   tail_restore_valid  one-cycle pulse; the ROB loads tail_restore_idx
//   tail_restore_idx    branch index + 1 (mod ROB_DEPTH)
//
// Optional build macro ROB_RECOVERY_STATS_EN adds two saturating counters:
//   stat_recoveries     accepted redirects
//   stat_walk_cycles    cycles with walk_valid high
// -----------------------------------------------------------------------------
module rob_recovery_ctrl #(
   parameter int ROB_DEPTH       = 32,
   parameter int IDX_W           = $clog2(ROB_DEPTH),
   parameter int ROLLBACK_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             redirect_valid,
   input  logic [IDX_W-1:0] redirect_rob_idx,
   input  logic [IDX_W-1:0] rob_head,
   input  logic [IDX_W-1:0] rob_tail,
   output logic [1:0]       rob_state,
   output logic             flush_valid,
   output logic             walk_valid,
   output logic [IDX_W-1:0] walk_idx,
   output logic             tail_restore_valid,
   output logic [IDX_W-1:0] tail_restore_idx
`ifdef ROB_RECOVERY_STATS_EN
   ,
   output logic [31:0]      stat_recoveries,
   output logic [31:0]      stat_walk_cycles
`endif
);

   localparam int CNT_W = (ROLLBACK_CYCLES > 1) ? $clog2(ROLLBACK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROLLBACK_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ROLLBACK = 2'b01,
      ST_WALK     = 2'b10
   } state_t;

   // Distance from the ROB head; a smaller age means an older entry.
   function automatic logic [IDX_W-1:0] age_of(input logic [IDX_W-1:0] idx,
                                               input logic [IDX_W-1:0] head);
      age_of = idx - head;
   endfunction

   state_t           state_q, state_n;
   logic [IDX_W-1:0] target_q, target_n;
   logic [IDX_W-1:0] cursor_q, cursor_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             flush_q, flush_n;
   logic             tr_valid_q, tr_valid_n;
   logic [IDX_W-1:0] tr_idx_q, tr_idx_n;
   logic [IDX_W-1:0] tgt_plus1;
   logic [IDX_W-1:0] base_tail;
   logic             older;
   logic             accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         target_q   <= '0;
         cursor_q   <= '0;
         cnt_q      <= '0;
         flush_q    <= 1'b0;
         tr_valid_q <= 1'b0;
         tr_idx_q   <= '0;
      end else begin
         state_q    <= state_n;
         target_q   <= target_n;
         cursor_q   <= cursor_n;
         cnt_q      <= cnt_n;
         flush_q    <= flush_n;
         tr_valid_q <= tr_valid_n;
         tr_idx_q   <= tr_idx_n;
      end
   end

   // The walk end (old tail) is never stored separately. The cursor starts at
   // end-1, so "entries remain" is simply cursor != target.
   always_comb begin
      state_n    = state_q;
      target_n   = target_q;
      cursor_n   = cursor_q;
      cnt_n      = cnt_q;
      flush_n    = 1'b0;
      tr_valid_n = 1'b0;
      tr_idx_n   = tr_idx_q;
      accept     = 1'b0;
      tgt_plus1  = target_q + 1'b1;
      // A redirect that coincides with the restore pulse must see the restored
      // tail. The ROB has not applied it to rob_tail yet.
      base_tail  = tr_valid_q ? tr_idx_q : rob_tail;
      older      = age_of(redirect_rob_idx, rob_head) < age_of(target_q, rob_head);

      unique case (state_q)
         ST_IDLE: begin
            if (redirect_valid) begin
               accept   = 1'b1;
               target_n = redirect_rob_idx;
               cursor_n = base_tail - 1'b1;
               cnt_n    = CNT_INIT;
               flush_n  = 1'b1;
               state_n  = ST_ROLLBACK;
            end
         end
         ST_ROLLBACK: begin
            if (cnt_q != '0) begin
               cnt_n = cnt_q - 1'b1;
            end else if (cursor_q != target_q) begin
               state_n = ST_WALK;
            end else begin
               state_n    = ST_IDLE;
               tr_valid_n = 1'b1;
               tr_idx_n   = tgt_plus1;
            end
         end
         ST_WALK: begin
            if (cursor_q == tgt_plus1) begin
               state_n    = ST_IDLE;
               tr_valid_n = 1'b1;
               tr_idx_n   = tgt_plus1;
            end else begin
               cursor_n = cursor_q - 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // An older redirect during recovery retargets the sequence. The entry
      // walked this cycle counts as done, so the cursor still steps down,
      // including past the old branch, which is now squashed as well. Any
      // pending restore is cancelled.
      if (state_q != ST_IDLE && redirect_valid && older) begin
         accept     = 1'b1;
         target_n   = redirect_rob_idx;
         cnt_n      = CNT_INIT;
         flush_n    = 1'b1;
         tr_valid_n = 1'b0;
         tr_idx_n   = tr_idx_q;
         state_n    = ST_ROLLBACK;
         if (state_q == ST_WALK) cursor_n = cursor_q - 1'b1;
      end
   end

   assign rob_state          = state_q;
   assign flush_valid        = flush_q;
   assign walk_valid         = (state_q == ST_WALK);
   assign walk_idx           = cursor_q;
   assign tail_restore_valid = tr_valid_q;
   assign tail_restore_idx   = tr_idx_q;

`ifdef ROB_RECOVERY_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_recoveries  <= '0;
         stat_walk_cycles <= '0;
      end else begin
         if (accept && stat_recoveries != '1) stat_recoveries <= stat_recoveries + 1'b1;
         if (walk_valid && stat_walk_cycles != '1) stat_walk_cycles <= stat_walk_cycles + 1'b1;
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule
